data_pipe_top_level: RTL

DATA_PIPE_TOP_LEVEL -- requirements
Module: data_pipe_top_level

---
 rtl/data_pipe_if.sv | 23 ++
 rtl/data_pipe_top_level.sv | 112 +++++++++++
 2 files changed

// File: rtl/data_pipe_if.sv
// data_pipe_if: issue and result handshake bundle for the two-stage ALU pipe
interface data_pipe_if #(
  parameter int REGWIDTH  = 5,
  parameter int DATAWIDTH = 32
);
  logic                 in_valid, in_ready;
  logic [REGWIDTH-1:0]  rs1, rs2, rd;
  logic                 RegWrite, ALUsrc;
  logic [2:0]           ALUctrl;
  logic [DATAWIDTH-1:0] ImmOp;
  logic                 out_valid, out_ready;
  logic [DATAWIDTH-1:0] ALUout, ALUop1, regOp2;
  logic                 EQ, out_RegWrite;
  logic [REGWIDTH-1:0]  out_rd;
  modport master (
    output in_valid, rs1, rs2, rd, RegWrite, ALUsrc, ALUctrl, ImmOp, out_ready,
    input  in_ready, out_valid, ALUout, ALUop1, regOp2, EQ, out_RegWrite, out_rd
  );
  modport slave (
    input  in_valid, rs1, rs2, rd, RegWrite, ALUsrc, ALUctrl, ImmOp, out_ready,
    output in_ready, out_valid, ALUout, ALUop1, regOp2, EQ, out_RegWrite, out_rd
  );
endinterface

// File: rtl/data_pipe_top_level.sv
// data_pipe_top_level: register file plus two-stage forwarding ALU pipeline
module data_pipe_top_level #(
  parameter int REGWIDTH  = 5,
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 wb_we,
  input  logic [REGWIDTH-1:0]  wb_rd,
  input  logic [DATAWIDTH-1:0] wb_data,
  output logic [DATAWIDTH-1:0] a0,
  data_pipe_if.slave           io
);
  localparam int NUMREGS = 2**REGWIDTH;
  localparam int SW      = $clog2(DATAWIDTH);
  if (REGWIDTH < 4) begin : g_rw_chk
    $error("REGWIDTH must be >= 4");
  end
  if (DATAWIDTH < 8 || (DATAWIDTH & (DATAWIDTH - 1)) != 0) begin : g_dw_chk
    $error("DATAWIDTH must be a power of two >= 8");
  end
  logic [DATAWIDTH-1:0] regs [NUMREGS];
  logic                 s1_valid, s1_rw, s1_src;
  logic [2:0]           s1_ctrl;
  logic [REGWIDTH-1:0]  s1_rd;
  logic [DATAWIDTH-1:0] s1_op1, s1_op2, s1_imm;
  logic                 s2_valid, s2_rw, s2_eq;
  logic [REGWIDTH-1:0]  s2_rd;
  logic [DATAWIDTH-1:0] s2_alu, s2_op1, s2_op2;
  logic                 s2_ready, accept;
  logic [DATAWIDTH-1:0] op2, alu, fwd1, fwd2;
  assign s2_ready    = !s2_valid || io.out_ready;
  assign io.in_ready = !s1_valid || s2_ready;
  assign accept      = io.in_valid && io.in_ready && !flush;
  assign op2         = s1_src ? s1_imm : s1_op2;
  assign a0          = regs[10];
  // Youngest producer wins: S1 result, then S2 result, then the same-cycle write port
  assign fwd1 = io.rs1 == '0 ? '0
              : (s1_valid && s1_rw && s1_rd == io.rs1) ? alu
              : (s2_valid && s2_rw && s2_rd == io.rs1) ? s2_alu
              : (wb_we && wb_rd == io.rs1) ? wb_data : regs[io.rs1];
  assign fwd2 = io.rs2 == '0 ? '0
              : (s1_valid && s1_rw && s1_rd == io.rs2) ? alu
              : (s2_valid && s2_rw && s2_rd == io.rs2) ? s2_alu
              : (wb_we && wb_rd == io.rs2) ? wb_data : regs[io.rs2];
  always_comb begin
    case (s1_ctrl)
      3'b000:  alu = s1_op1 + op2;
      3'b001:  alu = s1_op1 - op2;
      3'b010:  alu = s1_op1 & op2;
      3'b011:  alu = s1_op1 | op2;
      3'b100:  alu = s1_op1 ^ op2;
      3'b101:  alu = {{(DATAWIDTH-1){1'b0}}, $signed(s1_op1) < $signed(op2)};
      3'b110:  alu = s1_op1 << op2[SW-1:0];
      default: alu = s1_op1 >> op2[SW-1:0];
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_rw    <= 1'b0;
      s1_src   <= 1'b0;
      s1_ctrl  <= '0;
      s1_rd    <= '0;
      s1_op1   <= '0;
      s1_op2   <= '0;
      s1_imm   <= '0;
      s2_valid <= 1'b0;
      s2_rw    <= 1'b0;
      s2_eq    <= 1'b0;
      s2_rd    <= '0;
      s2_alu   <= '0;
      s2_op1   <= '0;
      s2_op2   <= '0;
    end else begin
      s1_valid <= !flush && (accept || (s1_valid && !s2_ready));
      s2_valid <= !flush && (s2_ready ? s1_valid : s2_valid);
      if (accept) begin
        s1_op1  <= fwd1;
        s1_op2  <= fwd2;
        s1_imm  <= io.ImmOp;
        s1_src  <= io.ALUsrc;
        s1_ctrl <= io.ALUctrl;
        s1_rd   <= io.rd;
        s1_rw   <= io.RegWrite;
      end
      if (s2_ready) begin
        s2_alu <= alu;
        s2_op1 <= s1_op1;
        s2_op2 <= s1_op2;
        s2_eq  <= s1_op1 == op2;
        s2_rd  <= s1_rd;
        s2_rw  <= s1_rw;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUMREGS; i++) regs[i] <= '0;
    end else if (wb_we && wb_rd != '0) begin
      regs[wb_rd] <= wb_data;
    end
  end
  assign io.out_valid    = s2_valid;
  assign io.ALUout       = s2_alu;
  assign io.ALUop1       = s2_op1;
  assign io.regOp2       = s2_op2;
  assign io.EQ           = s2_eq;
  assign io.out_RegWrite = s2_rw;
  assign io.out_rd       = s2_rd;
endmodule
